regfile_zflag: RTL and testbench
================================

Name: regfile_zflag

Overview:
Operand-supply stage directly upstream of the 8-bit ALU.
- Holds the CPU's general-purpose registers.
- Two combinational read ports drive the ALU's a and b operands.
- One synchronous write port takes the ALU result y (or any other write-back source).
- A zero-flag register captures the ALU zero output for the control unit's conditional jumps.

Parameters:
DATA_W, 8, register and operand width (matches ALU a/b/y).
ADDR_W, 4, register address width; register count = 2**ADDR_W.

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  synchronous, active-low reset, sampled on rising clk.
ra1  in  ADDR_W  read address, port 1 (ALU operand a).
ra2  in  ADDR_W  read address, port 2 (ALU operand b).
rd1  out  DATA_W  read data, port 1.
rd2  out  DATA_W  read data, port 2.
we3  in  1  register write enable.
wa3  in  ADDR_W  write address.
wd3  in  DATA_W  write data.
wez  in  1  zero-flag load enable.
zero_in  in  1  zero output from ALU.
z  out  1  registered zero flag.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits. Register 0 is hardwired to 0: writes to it are ignored and reads of it return 0.
- Reset:
  - When reset==0 at a rising clk edge, all registers become 0 and z becomes 0.
  - Reset overrides we3 and wez asserted in the same cycle.
  - Reset mid-operation discards any write pending in that cycle.
- Write:
  - On a rising clk with reset==1 and we3==1 and wa3!=0: reg[wa3] <= wd3.
  - Latency: 1 clk. The value is visible on rd1/rd2 after the edge.
- Read:
  - rd1 = (ra1==0) ? 0 : reg[ra1]; same for rd2/ra2.
  - Purely combinational, no clock latency.
  - ra1==ra2 is legal; both ports return the same value.
- Zero flag:
  - On a rising clk with reset==1 and wez==1: z <= zero_in.
  - Otherwise z holds its value.
  - wez and we3 are independent and may be asserted together.
- Simultaneous read/write of the same address in one cycle:
  - Without the bypass feature, reads return the old value until the edge.
  - See Optional Feature for the bypass case.
- Unknown (x/z) addresses must not corrupt other registers. Write only on a fully decoded wa3 match.
- No stalls or handshakes. Every write and flag load completes in the cycle it is asserted.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding is active.
  - If we3==1, wa3!=0 and ra1==wa3, then rd1 = wd3 in the same cycle; same for rd2.
  - Lets the control unit read back a result in the cycle it is written.
  - Forwarding is suppressed while reset==0, and rd ports then show stored contents.
- Undefined: no forwarding; reads always reflect stored contents.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W=8, ADDR_W=4 constants.
  - REG_ZERO address constant (0).
  - ALU opcode constants (OP_PASS_A..OP_NEG_B, 3 bits) so control, ALU and this block agree.
- One natural sub-module: zflag_reg, a 1-bit enable flip-flop with sync active-low reset. It is reused later for other status flags (carry).
- Storage array and read muxes stay inline.

Test Plan:
1. Hold reset=0 for 2 clks with we3=1, wa3=3, wd3=8'hAA, wez=1, zero_in=1 -> after release, rd1(ra1=3)=8'h00, z=0.
2. Write wa3=5, wd3=8'h3C, then wa3=9, wd3=8'hC3; set ra1=5, ra2=9 -> rd1=8'h3C, rd2=8'hC3; ra1=ra2=5 -> both 8'h3C.
3. Write wa3=0, wd3=8'hFF -> rd1(ra1=0)=8'h00 on the following cycle and thereafter.
4. Same-cycle write/read: wa3=ra1=7, wd3=8'h55, reg7 previously 8'h11:
   - bypass undefined -> rd1=8'h11 before the edge, 8'h55 after.
   - bypass defined -> rd1=8'h55 before the edge.
5. Zero flag: wez=1, zero_in=1 -> z=1 next cycle. wez=0, zero_in=0 for 3 clks -> z stays 1. wez=1, zero_in=0 -> z=0.
6. Loop with ALU: reg1=8'h05, reg2=8'h05, op=subtract, we3 to reg3, wez=1 -> reg3=8'h00, z=1. Repeat with reg2=8'h03 -> reg3=8'h02, z=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, hardwired-zero register address and ALU opcodes.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = ADDR_W'(0);

    // 3-bit ALU opcodes shared by control, ALU and operand supply
    typedef enum logic [2:0] {
        OP_PASS_A = 3'd0,
        OP_PASS_B = 3'd1,
        OP_ADD    = 3'd2,
        OP_SUB    = 3'd3,
        OP_AND    = 3'd4,
        OP_OR     = 3'd5,
        OP_XOR    = 3'd6,
        OP_NEG_B  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/zflag_reg.sv
// Single status-flag flip-flop with load enable and synchronous active-low reset.
module zflag_reg (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_zflag.sv
// ALU operand register file (2 comb read ports, 1 sync write port) plus zero-flag register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_zflag #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              wez,
    input  logic              zero_in,
    output logic              z
);

    import cpu_pkg::*;

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREG];

    // Per-register exact address match, so an unknown wa3 writes nothing
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q[0] <= '0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (we3 && (wa3 == ADDR_W'(i))) begin
                    regs_q[i] <= wd3;
                end
            end
        end
    end

    always_comb begin
        rd1 = (ra1 == ZERO_ADDR) ? '0 : regs_q[ra1];
        rd2 = (ra2 == ZERO_ADDR) ? '0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
        if (reset && we3 && (wa3 != ZERO_ADDR) && (ra1 == wa3)) begin
            rd1 = wd3;
        end
        if (reset && we3 && (wa3 != ZERO_ADDR) && (ra2 == wa3)) begin
            rd2 = wd3;
        end
`endif
    end

    zflag_reg u_zflag (
        .clk   (clk),
        .reset (reset),
        .en    (wez),
        .d     (zero_in),
        .q     (z)
    );

endmodule

// File: tb/tb_regfile_zflag.sv
// Table-driven bench for regfile_zflag; inputs driven on negedge, outputs sampled 1ns later.
module tb_regfile_zflag;

    logic       clk;
    logic       reset;
    logic [3:0] ra1, ra2, wa3;
    logic [7:0] rd1, rd2, wd3;
    logic       we3, wez, zero_in, z;

    int errors = 0;
    int checks = 0;

    regfile_zflag dut (
        .clk     (clk),
        .reset   (reset),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .wez     (wez),
        .zero_in (zero_in),
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       we3;
        logic [3:0] wa3;
        logic [7:0] wd3;
        logic       wez;
        logic       zin;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic       chk;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       ez;
    } vec_t;

`ifdef REGFILE_BYPASS_EN
    localparam logic [7:0] SAME_CYC_R7 = 8'h55;
`else
    localparam logic [7:0] SAME_CYC_R7 = 8'h11;
`endif

    vec_t vq[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] wa, input logic [7:0] wd,
                         input logic ze, input logic zi, input logic [3:0] a1, input logic [3:0] a2);
        @(negedge clk);
        reset = r; we3 = w; wa3 = wa; wd3 = wd; wez = ze; zero_in = zi; ra1 = a1; ra2 = a2;
        #1;
    endtask

    // Reference 8-bit subtract for the ALU loop sequence
    function automatic logic [7:0] alu_sub(input logic [7:0] a, input logic [7:0] b);
        return a - b;
    endfunction

    initial begin
        logic [7:0] y;
        reset = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0; wez = 1'b0; zero_in = 1'b0; ra1 = '0; ra2 = '0;

        //            rst we3 wa3    wd3    wez zin ra1    ra2   chk  e1     e2     ez
        vq.push_back('{1'b0,1'b1,4'd3,8'hAA,1'b1,1'b1,4'd3,4'd0,1'b0,8'h00,8'h00,1'b0});
        vq.push_back('{1'b0,1'b1,4'd3,8'hAA,1'b1,1'b1,4'd3,4'd0,1'b1,8'h00,8'h00,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd3,4'd3,1'b1,8'h00,8'h00,1'b0});
        vq.push_back('{1'b1,1'b1,4'd5,8'h3C,1'b0,1'b0,4'd1,4'd2,1'b1,8'h00,8'h00,1'b0});
        vq.push_back('{1'b1,1'b1,4'd9,8'hC3,1'b0,1'b0,4'd5,4'd5,1'b1,8'h3C,8'h3C,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd5,4'd9,1'b1,8'h3C,8'hC3,1'b0});
        vq.push_back('{1'b1,1'b1,4'd0,8'hFF,1'b0,1'b0,4'd0,4'd0,1'b1,8'h00,8'h00,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd0,4'd9,1'b1,8'h00,8'hC3,1'b0});
        vq.push_back('{1'b1,1'b1,4'd7,8'h11,1'b0,1'b0,4'd0,4'd5,1'b1,8'h00,8'h3C,1'b0});
        vq.push_back('{1'b1,1'b1,4'd7,8'h55,1'b0,1'b0,4'd7,4'd9,1'b1,SAME_CYC_R7,8'hC3,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd7,4'd7,1'b1,8'h55,8'h55,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b1,1'b1,4'd0,4'd0,1'b1,8'h00,8'h00,1'b0});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd0,4'd0,1'b1,8'h00,8'h00,1'b1});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd0,4'd0,1'b1,8'h00,8'h00,1'b1});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd0,4'd0,1'b1,8'h00,8'h00,1'b1});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b1,1'b0,4'd0,4'd0,1'b1,8'h00,8'h00,1'b1});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b1,4'd0,4'd0,1'b1,8'h00,8'h00,1'b0});
        // Reset mid-operation: pending write and flag load are dropped, no forwarding
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b1,1'b1,4'd5,4'd9,1'b1,8'h3C,8'hC3,1'b0});
        vq.push_back('{1'b0,1'b1,4'd5,8'h77,1'b1,1'b1,4'd5,4'd9,1'b1,8'h3C,8'hC3,1'b1});
        vq.push_back('{1'b1,1'b0,4'd0,8'h00,1'b0,1'b0,4'd5,4'd9,1'b1,8'h00,8'h00,1'b0});

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].we3, vq[i].wa3, vq[i].wd3, vq[i].wez, vq[i].zin, vq[i].ra1, vq[i].ra2);
            if (vq[i].chk) begin
                check8($sformatf("vec%0d_rd1", i), rd1, vq[i].e1);
                check8($sformatf("vec%0d_rd2", i), rd2, vq[i].e2);
                check8($sformatf("vec%0d_z", i), {7'd0, z}, {7'd0, vq[i].ez});
            end
        end

        // Unknown write address must leave every register untouched
        drive(1'b1, 1'b1, 4'd4, 8'h44, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 4'bxxxx, 8'hEE, 1'b0, 1'b0, 4'd4, 4'd5);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd4, 4'd5);
        check8("xaddr_r4", rd1, 8'h44);
        check8("xaddr_r5", rd2, 8'h00);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd15);
        check8("xaddr_r1", rd1, 8'h00);
        check8("xaddr_r15", rd2, 8'h00);

        // ALU loop: reg3 = reg1 - reg2, zero flag from the result
        drive(1'b1, 1'b1, 4'd1, 8'h05, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 4'd2, 8'h05, 1'b0, 1'b0, 4'd0, 4'd0);
        y = alu_sub(8'h05, 8'h05);
        drive(1'b1, 1'b1, 4'd3, y, 1'b1, (y == 8'h00), 4'd1, 4'd2);
        check8("alu1_a", rd1, 8'h05);
        check8("alu1_b", rd2, 8'h05);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd3, 4'd0);
        check8("alu1_reg3", rd1, 8'h00);
        check8("alu1_z", {7'd0, z}, 8'h01);

        drive(1'b1, 1'b1, 4'd2, 8'h03, 1'b0, 1'b0, 4'd0, 4'd0);
        y = alu_sub(8'h05, 8'h03);
        drive(1'b1, 1'b1, 4'd3, y, 1'b1, (y == 8'h00), 4'd1, 4'd2);
        check8("alu2_a", rd1, 8'h05);
        check8("alu2_b", rd2, 8'h03);
        drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd3, 4'd0);
        check8("alu2_reg3", rd1, 8'h02);
        check8("alu2_z", {7'd0, z}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
